conv_out_writer: RTL

CONV_OUT_WRITER -- requirements
Module: conv_out_writer

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_out_writer_if.sv | 30 +++
 rtl/conv_skid_fifo.sv | 72 +++++++
 rtl/conv_out_writer.sv | 111 +++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type and output-geometry helpers for the conv output writer
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } writer_state_t;

  // Edge length of a valid (no padding, stride 1) convolution output
  function automatic int conv_out_dim(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  // Number of result words making up one output frame
  function automatic int conv_out_pixels(input int image_size, input int kernel_size);
    return conv_out_dim(image_size, kernel_size) * conv_out_dim(image_size, kernel_size);
  endfunction

endpackage

// File: rtl/conv_out_writer_if.sv
// rtl/conv_out_writer_if.sv - result stream in, output buffer write port out, frame status
interface conv_out_writer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);

  logic                  arm;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH:0]   wr_count;
  logic                  done;

  // Controller / producer / buffer side
  modport master (
    output arm, in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, wr_count, done
  );

  // Writer side
  modport slave (
    input  arm, in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, wr_count, done
  );

endinterface

// File: rtl/conv_skid_fifo.sv
// rtl/conv_skid_fifo.sv - two-entry FIFO decoupling result acceptance from buffer writes
module conv_skid_fifo #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] slot_q [2];
  logic [DATA_WIDTH-1:0] slot_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign head    = slot_q[rd_ptr_q];
  // A push against a full FIFO is dropped here even if a pop happens the same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers/occupancy; flush wins and leaves stale slot contents unreachable
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        slot_d[wr_ptr_q] = push_data;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      slot_q    <= slot_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/conv_out_writer.sv
// rtl/conv_out_writer.sv - writes one frame of conv results to the output buffer in raster order (CONV_WRITER_RELU_EN clamps negative words to zero)
module conv_out_writer
  import conv_pkg::*;
#(
  parameter int IMAGE_SIZE  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  conv_out_writer_if.slave bus
);

  localparam int                  OUT_PIXELS = conv_out_pixels(IMAGE_SIZE, KERNEL_SIZE);
  localparam int                  LAST_IDX   = OUT_PIXELS - 1;
  localparam logic [ADDR_WIDTH:0] PIX_CNT    = OUT_PIXELS[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LAST_CNT   = LAST_IDX[ADDR_WIDTH:0];

  writer_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
  logic [ADDR_WIDTH:0]   acc_count_q, acc_count_d;
  logic                  done_q, done_d;

  logic                  fifo_full, fifo_empty;
  logic                  in_ready, mem_we, push;
  logic [DATA_WIDTH-1:0] push_data, fifo_head;

  // Ready depends only on registered state so it never loops back through in_valid
  assign in_ready = (state_q == ST_RUN) && !fifo_full && (acc_count_q < PIX_CNT);
  assign mem_we   = (state_q == ST_RUN) && !fifo_empty && bus.mem_ready;
  assign push     = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = wr_count_q[ADDR_WIDTH-1:0];
  assign bus.mem_wdata = fifo_head;
  assign bus.wr_count  = wr_count_q;
  assign bus.done      = done_q;

  // Word entering the FIFO; optional clamp of sign-bit words adds no latency
  always_comb begin
    push_data = bus.in_data;
`ifdef CONV_WRITER_RELU_EN
    if (bus.in_data[DATA_WIDTH-1]) begin
      push_data = '0;
    end
`endif
  end

  conv_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.arm),
    .push      (push),
    .push_data (push_data),
    .pop       (mem_we),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame sequencing; arm restarts from any state and discards counts
  always_comb begin
    state_d     = state_q;
    wr_count_d  = wr_count_q;
    acc_count_d = acc_count_q;
    done_d      = done_q;
    if (bus.arm) begin
      state_d     = ST_RUN;
      wr_count_d  = '0;
      acc_count_d = '0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (push) begin
            acc_count_d = acc_count_q + 1'b1;
          end
          if (mem_we) begin
            wr_count_d = wr_count_q + 1'b1;
            if (wr_count_q == LAST_CNT) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DONE: done_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_count_q  <= '0;
      acc_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      acc_count_q <= acc_count_d;
      done_q      <= done_d;
    end
  end

endmodule
